// File: rtl/alu_iter.sv
// Integer execute unit: RV32I ops in one cycle, RV32M multiply/divide on an
// iterative radix-2 engine, valid/ready on both sides with a registered result.
module alu_iter #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int unsigned SHW   = $clog2(XLEN);
   localparam int unsigned CNT_W = SHW + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_XOR = 5'd2,  OP_OR = 5'd3;
   localparam logic [4:0] OP_AND = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
   localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
   localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

   state_e              state_q, state_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [4:0]          op_q, op_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic                neg_q, neg_d, negr_q, negr_d;
   logic                out_valid_q, out_valid_d;
   logic [XLEN-1:0]     out_result_q, out_result_d;
   logic [TAG_W-1:0]    out_tag_q, out_tag_d;

   logic                accept, is_mul, is_div, sign_a, sign_b, sa, sb;
   logic                div_zero, div_ovf, div_special, cnt_done, engine_go;
   logic [XLEN-1:0]     mag_a, mag_b, simple_res, fin_res, quo_mag, rem_mag;
   logic [SHW-1:0]      shamt;
   logic [XLEN:0]       mul_sum, div_trial;
   logic [2*XLEN-1:0]   mul_step, div_step, mul_p;

   // Input decode, operand magnitudes and special-case detection
   assign is_mul      = in_op inside {[OP_MUL:OP_MULHU]};
   assign is_div      = in_op inside {[OP_DIV:OP_REMU]};
   assign sign_a      = in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   assign sign_b      = in_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   assign sa          = sign_a && in_a[XLEN-1];
   assign sb          = sign_b && in_b[XLEN-1];
   assign mag_a       = sa ? -in_a : in_a;
   assign mag_b       = sb ? -in_b : in_b;
   assign div_zero    = (in_b == '0);
   assign div_ovf     = (in_op == OP_DIV || in_op == OP_REM) && (in_a == MOST_NEG) && (in_b == '1);
   assign div_special = is_div && (div_zero || div_ovf);
   assign engine_go   = is_mul || (is_div && !div_special);
   assign shamt       = in_b[SHW-1:0];
   assign accept      = in_valid && in_ready && !flush;
   assign cnt_done    = (cnt_q == CNT_W'(XLEN));

   always_comb begin : alu_simple
      simple_res = '0;
      case (in_op)
         OP_ADD:          simple_res = in_a + in_b;
         OP_SUB:          simple_res = in_a - in_b;
         OP_XOR:          simple_res = in_a ^ in_b;
         OP_OR:           simple_res = in_a | in_b;
         OP_AND:          simple_res = in_a & in_b;
         OP_SLL:          simple_res = in_a << shamt;
         OP_SRL:          simple_res = in_a >> shamt;
         OP_SRA:          simple_res = XLEN'($signed(in_a) >>> shamt);
         OP_SLT:          simple_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         OP_SLTU:         simple_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
         OP_DIV, OP_DIVU: simple_res = div_zero ? '1 : in_a;
         OP_REM, OP_REMU: simple_res = div_zero ? in_a : '0;
         default:         simple_res = '0;
      endcase
   end

   // One radix-2 step of shift-add multiply and of restoring division
   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_step  = {mul_sum, acc_q[XLEN-1:1]};
   assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   always_comb begin : div_iter
      if (div_trial >= {1'b0, opnd_q}) begin
         div_step = {XLEN'(div_trial - {1'b0, opnd_q}), acc_q[XLEN-2:0], 1'b1};
      end else begin
         div_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
   end

   // Sign fix-up and result select on completion
   assign mul_p   = neg_q ? -acc_q : acc_q;
   assign quo_mag = acc_q[XLEN-1:0];
   assign rem_mag = acc_q[2*XLEN-1:XLEN];
   always_comb begin : finish_sel
      fin_res = '0;
      case (op_q)
         OP_MUL:                         fin_res = mul_p[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:   fin_res = mul_p[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:                fin_res = neg_q ? -quo_mag : quo_mag;
         OP_REM, OP_REMU:                fin_res = negr_q ? -rem_mag : rem_mag;
         default:                        fin_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         S_IDLE:       if (accept && is_mul) state_d = S_MUL;
                       else if (accept && is_div && !div_special) state_d = S_DIV;
         S_MUL, S_DIV: if (cnt_done) state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_comb begin : outputs
      in_ready     = (state_q == S_IDLE) && (!out_valid_q || out_ready);
      busy         = (state_q != S_IDLE);
      acc_d        = acc_q;
      opnd_d       = opnd_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      tag_d        = tag_q;
      neg_d        = neg_q;
      negr_d       = negr_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
      case (state_q)
         S_IDLE: if (accept) begin
            if (engine_go) begin
               acc_d  = {{XLEN{1'b0}}, is_mul ? mag_b : mag_a};
               opnd_d = is_mul ? mag_a : mag_b;
               cnt_d  = '0;
               op_d   = in_op;
               tag_d  = in_tag;
               neg_d  = sa ^ sb;
               negr_d = sa;
            end else begin
               out_valid_d  = 1'b1;
               out_result_d = simple_res;
               out_tag_d    = in_tag;
            end
         end
         S_MUL, S_DIV: if (cnt_done) begin
            out_valid_d  = 1'b1;
            out_result_d = fin_res;
            out_tag_d    = tag_q;
         end else begin
            acc_d = (state_q == S_MUL) ? mul_step : div_step;
            cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
      if (flush) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin : data_reg
      if (!rst_n) begin
         acc_q        <= '0;
         opnd_q       <= '0;
         cnt_q        <= '0;
         op_q         <= '0;
         tag_q        <= '0;
         neg_q        <= 1'b0;
         negr_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
      end else begin
         acc_q        <= acc_d;
         opnd_q       <= opnd_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         neg_q        <= neg_d;
         negr_q       <= negr_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_tag_q    <= out_tag_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;

endmodule
